// File: rtl/atm_kp_pkg.sv
// Shared constants and types for the ATM keypad front-end.
//   KEY_*  : keypad codes with a control meaning (digits are 0-9)
//   OP_*   : operation codes as understood by the ATM core
//   kp_state_t : entry FSM state, also exported on entry_state
package atm_kp_pkg;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;

  localparam logic [2:0] OP_NONE       = 3'd0;
  localparam logic [2:0] OP_BALANCE    = 3'd3;
  localparam logic [2:0] OP_WITHDRAW   = 3'd4;
  localparam logic [2:0] OP_DEPOSIT    = 3'd5;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC    = 3'd1,
    PIN    = 3'd2,
    OP     = 3'd3,
    AMT    = 3'd4,
    NEWPIN = 3'd5,
    REQ    = 3'd6
  } kp_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_bcd_pin_collector.sv
// Four-digit packed-BCD shift register, first digit ends up in [15:12].
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clr         : synchronous clear of value and digit count
//   shift       : shift digit in (ignored once four digits are held)
//   digit       : BCD digit to shift in
//   value       : collected digits
//   full_c      : four digits held
//   enter_ok_c  : entry may be confirmed with ENTER
module atm_bcd_pin_collector
  import atm_kp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [3:0]  digit,
  output logic [15:0] value,
  output logic        full_c,
  output logic        enter_ok_c
);

  logic [2:0] count;

  assign full_c     = (count == 3'd4);
  assign enter_ok_c = (count == 3'd4);

  // Shift MSB-first; a fifth digit is dropped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      count <= '0;
    end else if (shift && !full_c) begin
      value <= {value[11:0], digit};
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad front-end: assembles keypresses into one request (account, PIN,
// operation, amount or new PIN) and offers it to the core via valid/ready.
// Optional feature macro: ATM_KP_TIMEOUT_EN (inactivity abort).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   key_valid/code  : one-cycle key strobe and its code
//   req_ready       : core accepts request
//   req_valid       : request fields valid and held
//   operation       : 3..6 = BALANCE/WITHDRAW/DEPOSIT/CHANGE_PIN
//   acc_num         : account index
//   pin, newPin     : packed BCD PINs
//   amount          : binary amount
//   entry_state     : current FSM state
//   timeout_pulse   : one-cycle pulse on inactivity abort
module atm_keypad_entry
  import atm_kp_pkg::*;
#(
  parameter int unsigned AMT_DIGITS     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        req_ready,
  output logic        req_valid,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] newPin,
  output logic [31:0] amount,
  output logic [2:0]  entry_state,
  output logic        timeout_pulse
);

  localparam int unsigned AMT_W = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO_W  = 32;

  if (AMT_DIGITS == 0 || AMT_DIGITS > 9) begin : g_bad_amt_digits
    $error("atm_keypad_entry: AMT_DIGITS must be 1..9");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("atm_keypad_entry: TIMEOUT_CYCLES must be >= 2");
  end

  kp_state_t state, state_next;
  logic [CNT_W-1:0] amt_cnt;
  logic digit;
  logic timeout_hit;
  logic acc_load, acc_clr, pin_shift, pin_clr, np_shift, np_clr;
  logic op_load, op_clr, amt_add, amt_clr, clear_all;
  logic pin_full_c, pin_ok_c, np_full_c, np_ok_c;

  assign digit       = is_digit(key_code);
  assign entry_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and field-update strobes.
  always_comb begin
    state_next = state;
    acc_load   = 1'b0;
    acc_clr    = 1'b0;
    pin_shift  = 1'b0;
    pin_clr    = 1'b0;
    np_shift   = 1'b0;
    np_clr     = 1'b0;
    op_load    = 1'b0;
    op_clr     = 1'b0;
    amt_add    = 1'b0;
    amt_clr    = 1'b0;
    clear_all  = 1'b0;
    if (timeout_hit) begin
      state_next = IDLE;
      clear_all  = 1'b1;
    end else if (state == REQ) begin
      // Keys are ignored while the request is offered.
      if (req_valid && req_ready) begin
        state_next = IDLE;
        clear_all  = 1'b1;
      end
    end else if (key_valid) begin
      if (key_code == KEY_CANCEL) begin
        state_next = IDLE;
        clear_all  = 1'b1;
      end else begin
        unique case (state)
          IDLE: if (digit) begin
            acc_load   = 1'b1;
            state_next = ACC;
          end
          ACC: begin
            if (digit)                        acc_load   = 1'b1;
            else if (key_code == KEY_ENTER)   state_next = PIN;
            else if (key_code == KEY_CLEAR)   acc_clr    = 1'b1;
          end
          PIN: begin
            if (digit)                        pin_shift  = !pin_full_c;
            else if (key_code == KEY_ENTER)   state_next = pin_ok_c ? OP : PIN;
            else if (key_code == KEY_CLEAR)   pin_clr    = 1'b1;
          end
          OP: begin
            if (digit)                        op_load = (key_code >= 4'd1) && (key_code <= 4'd4);
            else if (key_code == KEY_CLEAR)   op_clr  = 1'b1;
            else if (key_code == KEY_ENTER) begin
              case (operation)
                OP_BALANCE:             state_next = REQ;
                OP_WITHDRAW, OP_DEPOSIT: state_next = AMT;
                OP_CHANGE_PIN:          state_next = NEWPIN;
                default:                state_next = OP;
              endcase
            end
          end
          AMT: begin
            if (digit)                        amt_add    = (amt_cnt < CNT_W'(AMT_DIGITS));
            else if (key_code == KEY_ENTER)   state_next = (amount != '0) ? REQ : AMT;
            else if (key_code == KEY_CLEAR)   amt_clr    = 1'b1;
          end
          NEWPIN: begin
            if (digit)                        np_shift   = !np_full_c;
            else if (key_code == KEY_ENTER)   state_next = np_ok_c ? REQ : NEWPIN;
            else if (key_code == KEY_CLEAR)   np_clr     = 1'b1;
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // Account, operation, amount and request-valid registers.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      acc_num   <= '0;
      operation <= OP_NONE;
      amount    <= '0;
      amt_cnt   <= '0;
      req_valid <= 1'b0;
    end else begin
      req_valid <= (state_next == REQ);
      if (acc_load)     acc_num   <= key_code;
      else if (acc_clr) acc_num   <= '0;
      if (op_load)      operation <= 3'(key_code) + 3'd2;
      else if (op_clr)  operation <= OP_NONE;
      if (amt_add) begin
        amount  <= amount * AMT_W'(10) + AMT_W'(key_code);
        amt_cnt <= amt_cnt + CNT_W'(1);
      end else if (amt_clr) begin
        amount  <= '0;
        amt_cnt <= '0;
      end
    end
  end

  atm_bcd_pin_collector u_pin (
    .clk        (clk),
    .rst        (rst),
    .clr        (pin_clr || clear_all),
    .shift      (pin_shift),
    .digit      (key_code),
    .value      (pin),
    .full_c     (pin_full_c),
    .enter_ok_c (pin_ok_c)
  );

  atm_bcd_pin_collector u_newpin (
    .clk        (clk),
    .rst        (rst),
    .clr        (np_clr || clear_all),
    .shift      (np_shift),
    .digit      (key_code),
    .value      (newPin),
    .full_c     (np_full_c),
    .enter_ok_c (np_ok_c)
  );

`ifdef ATM_KP_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_cnt;
  logic            entry_active;

  assign entry_active = (state != IDLE) && (state != REQ);
  // A key on the terminal cycle suppresses the abort.
  assign timeout_hit  = entry_active && !key_valid && (idle_cnt == TO_LAST);

  // Inactivity counter and abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      if (key_valid || !entry_active || timeout_hit) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed self-checking bench for atm_keypad_entry.
// Inputs change and outputs are sampled on the falling edge.
module tb_atm_keypad_entry;
  import atm_kp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, key_valid, req_ready;
  logic [3:0]  key_code;
  logic        req_valid, timeout_pulse;
  logic [2:0]  operation, entry_state;
  logic [3:0]  acc_num;
  logic [15:0] pin, newPin;
  logic [31:0] amount;
  int nvec, nerr;

  always #5 clk = ~clk;

  atm_keypad_entry #(.AMT_DIGITS(6), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .req_ready(req_ready), .req_valid(req_valid), .operation(operation),
    .acc_num(acc_num), .pin(pin), .newPin(newPin), .amount(amount),
    .entry_state(entry_state), .timeout_pulse(timeout_pulse)
  );

  // One key for one cycle; returns on the falling edge after it was sampled.
  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Keys packed as nibbles, first key in the most significant used nibble.
  task automatic send_seq(input logic [63:0] seq, input int n);
    for (int i = 0; i < n; i++) key(seq[4*(n-1-i) +: 4]);
  endtask

  task automatic test_reset;
    @(negedge clk);
    nvec++;
    if ({req_valid, operation, acc_num, pin, newPin, amount, entry_state, timeout_pulse} !== 76'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got rv=%b op=%0d acc=%0d pin=%h np=%h amt=%0d st=%0d to=%b required all 0",
               req_valid, operation, acc_num, pin, newPin, amount, entry_state, timeout_pulse);
    end
    rst = 1'b0;
    key(KEY_ENTER); key(KEY_CLEAR); key(4'hE); key(KEY_CANCEL);
    nvec++;
    if ({entry_state, acc_num} !== {3'(IDLE), 4'd0}) begin
      nerr++;
      $display("FAIL idle_ignores: got st=%0d acc=%0d required st=0 acc=0", entry_state, acc_num);
    end
  endtask

  task automatic test_balance;
    req_ready = 1'b1;
    send_seq(64'h3A1234A1A, 9);
    nvec++;
    if ({req_valid, operation, acc_num, pin, newPin, amount, entry_state} !== {1'b1, 3'd3, 4'd3, 16'h1234, 16'h0, 32'd0, 3'(REQ)}) begin
      nerr++;
      $display("FAIL balance_req: got rv=%b op=%0d acc=%0d pin=%h np=%h amt=%0d st=%0d required rv=1 op=3 acc=3 pin=1234 np=0 amt=0 st=6",
               req_valid, operation, acc_num, pin, newPin, amount, entry_state);
    end
    @(negedge clk);
    nvec++;
    if ({req_valid, operation, acc_num, pin, entry_state} !== {1'b0, 3'd0, 4'd0, 16'h0, 3'(IDLE)}) begin
      nerr++;
      $display("FAIL balance_accept: got rv=%b op=%0d acc=%0d pin=%h st=%0d required all 0",
               req_valid, operation, acc_num, pin, entry_state);
    end
    req_ready = 1'b0;
  endtask

  task automatic test_withdraw_hold;
    send_seq(64'h7A9876A2A500A, 13);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) key(KEY_CANCEL);
      else        @(negedge clk);
      nvec++;
      if ({req_valid, operation, acc_num, pin, newPin, amount, entry_state} !== {1'b1, 3'd4, 4'd7, 16'h9876, 16'h0, 32'd500, 3'(REQ)}) begin
        nerr++;
        $display("FAIL withdraw_hold[%0d]: got rv=%b op=%0d acc=%0d pin=%h np=%h amt=%0d st=%0d required rv=1 op=4 acc=7 pin=9876 np=0 amt=500 st=6",
                 c, req_valid, operation, acc_num, pin, newPin, amount, entry_state);
      end
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    nvec++;
    if ({req_valid, amount, entry_state} !== {1'b0, 32'd0, 3'(IDLE)}) begin
      nerr++;
      $display("FAIL withdraw_accept: got rv=%b amt=%0d st=%0d required rv=0 amt=0 st=0", req_valid, amount, entry_state);
    end
  endtask

  task automatic test_change_pin;
    send_seq(64'h1A4444A4A12C5678, 16);
    key(KEY_ENTER);
    nvec++;
    if ({req_valid, operation, acc_num, pin, newPin, amount} !== {1'b1, 3'd6, 4'd1, 16'h4444, 16'h5678, 32'd0}) begin
      nerr++;
      $display("FAIL change_pin: got rv=%b op=%0d acc=%0d pin=%h np=%h amt=%0d required rv=1 op=6 acc=1 pin=4444 np=5678 amt=0",
               req_valid, operation, acc_num, pin, newPin, amount);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    nvec++;
    if ({req_valid, newPin, entry_state} !== {1'b0, 16'h0, 3'(IDLE)}) begin
      nerr++;
      $display("FAIL change_pin_accept: got rv=%b np=%h st=%0d required rv=0 np=0 st=0", req_valid, newPin, entry_state);
    end
  endtask

  task automatic test_pin_rules;
    send_seq(64'h2A123A, 6);
    nvec++;
    if ({entry_state, pin} !== {3'(PIN), 16'h0123}) begin
      nerr++;
      $display("FAIL pin_short_enter: got st=%0d pin=%h required st=2 pin=0123", entry_state, pin);
    end
    send_seq(64'h49A, 3);
    nvec++;
    if ({entry_state, pin, acc_num} !== {3'(OP), 16'h1234, 4'd2}) begin
      nerr++;
      $display("FAIL pin_fifth_digit: got st=%0d pin=%h acc=%0d required st=3 pin=1234 acc=2", entry_state, pin, acc_num);
    end
    key(4'd7); key(4'd2);
    nvec++;
    if (operation !== 3'd4) begin
      nerr++;
      $display("FAIL op_latch: got op=%0d required 4", operation);
    end
    key(KEY_CLEAR); key(KEY_ENTER);
    nvec++;
    if ({entry_state, operation} !== {3'(OP), 3'd0}) begin
      nerr++;
      $display("FAIL op_clear: got st=%0d op=%0d required st=3 op=0", entry_state, operation);
    end
    key(4'd3); key(KEY_ENTER); key(4'd4);
    nvec++;
    if ({entry_state, operation, amount} !== {3'(AMT), 3'd5, 32'd4}) begin
      nerr++;
      $display("FAIL op_to_amt: got st=%0d op=%0d amt=%0d required st=4 op=5 amt=4", entry_state, operation, amount);
    end
    key(KEY_CANCEL);
    nvec++;
    if ({req_valid, operation, acc_num, pin, newPin, amount, entry_state} !== 75'h0) begin
      nerr++;
      $display("FAIL cancel_amt: got rv=%b op=%0d acc=%0d pin=%h np=%h amt=%0d st=%0d required all 0",
               req_valid, operation, acc_num, pin, newPin, amount, entry_state);
    end
  endtask

  task automatic test_amount;
    send_seq(64'h5A1111A3A, 9);
    key(KEY_ENTER);
    nvec++;
    if ({entry_state, amount} !== {3'(AMT), 32'd0}) begin
      nerr++;
      $display("FAIL amt_zero_enter: got st=%0d amt=%0d required st=4 amt=0", entry_state, amount);
    end
    send_seq(64'h12C, 3);
    nvec++;
    if ({entry_state, amount} !== {3'(AMT), 32'd0}) begin
      nerr++;
      $display("FAIL amt_clear: got st=%0d amt=%0d required st=4 amt=0", entry_state, amount);
    end
    send_seq(64'h99999999, 8);
    nvec++;
    if (amount !== 32'd999999) begin
      nerr++;
      $display("FAIL amt_max_digits: got amt=%0d required 999999", amount);
    end
    key(KEY_ENTER);
    nvec++;
    if ({req_valid, operation, amount} !== {1'b1, 3'd5, 32'd999999}) begin
      nerr++;
      $display("FAIL amt_req: got rv=%b op=%0d amt=%0d required rv=1 op=5 amt=999999", req_valid, operation, amount);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
  endtask

  task automatic test_reset_in_req;
    send_seq(64'h3A1234A1A, 9);
    nvec++;
    if (req_valid !== 1'b1) begin
      nerr++;
      $display("FAIL req_before_rst: got rv=%b required 1", req_valid);
    end
    rst = 1'b1;
    req_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_ready = 1'b0;
    nvec++;
    if ({req_valid, operation, acc_num, pin, entry_state} !== {1'b0, 3'd0, 4'd0, 16'h0, 3'(IDLE)}) begin
      nerr++;
      $display("FAIL rst_in_req: got rv=%b op=%0d acc=%0d pin=%h st=%0d required all 0",
               req_valid, operation, acc_num, pin, entry_state);
    end
  endtask

`ifdef ATM_KP_TIMEOUT_EN
  task automatic test_timeout;
    int pulses;
    send_seq(64'h1A1234, 6);
    pulses = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (timeout_pulse === 1'b1) pulses++;
    end
    nvec++;
    if ({pulses[3:0], entry_state} !== {4'd0, 3'(PIN)}) begin
      nerr++;
      $display("FAIL timeout_early: got pulses=%0d st=%0d required pulses=0 st=2", pulses, entry_state);
    end
    @(negedge clk);
    nvec++;
    if ({timeout_pulse, entry_state, pin, acc_num} !== {1'b1, 3'(IDLE), 16'h0, 4'd0}) begin
      nerr++;
      $display("FAIL timeout_abort: got to=%b st=%0d pin=%h acc=%0d required to=1 st=0 pin=0 acc=0",
               timeout_pulse, entry_state, pin, acc_num);
    end
    @(negedge clk);
    nvec++;
    if (timeout_pulse !== 1'b0) begin
      nerr++;
      $display("FAIL timeout_one_cycle: got to=%b required 0", timeout_pulse);
    end
    send_seq(64'h1A1234, 6);
    repeat (15) @(negedge clk);
    key(4'd5);
    nvec++;
    if ({timeout_pulse, entry_state, pin} !== {1'b0, 3'(PIN), 16'h1234}) begin
      nerr++;
      $display("FAIL timeout_key_wins: got to=%b st=%0d pin=%h required to=0 st=2 pin=1234",
               timeout_pulse, entry_state, pin);
    end
    key(KEY_CANCEL);
  endtask
`endif

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    req_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_balance;
    test_withdraw_hold;
    test_change_pin;
    test_pin_rules;
    test_amount;
    test_reset_in_req;
`ifdef ATM_KP_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
